// File: rtl/gpio_debounce.sv
// Per-channel button conditioner: 2-flop synchronizer followed by a stability counter.
// Define GPIO_DEBOUNCE_EDGE_EN to get registered 1-cycle rise_o/fall_o pulses; otherwise they are tied to 0.
module gpio_debounce #(
  parameter int WIDTH           = 3,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 30000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cfg
    $fatal(1, "gpio_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Any cycle where the synchronized input matches the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign level_o = level_q;

`ifdef GPIO_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q, fall_q;

  // Pulses are registered on the same edge that moves level_q, so they align with level_o.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= level_d & ~level_q;
      fall_q <= ~level_d & level_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Self-checking bench for gpio_debounce (WIDTH=3, CNT_W=4, DEBOUNCE_CYCLES=4).
// Edge-pulse expectations are masked to 0 unless GPIO_DEBOUNCE_EDGE_EN is defined.
module tb_gpio_debounce;

  logic       clk;
  logic       rstN;
  logic [2:0] btn;
  logic [2:0] level, rise, fall;

  int checkCount = 0;
  int errorCount = 0;

`ifdef GPIO_DEBOUNCE_EDGE_EN
  localparam logic [2:0] EdgeMask = 3'b111;
`else
  localparam logic [2:0] EdgeMask = 3'b000;
`endif

  typedef struct {
    logic       rstN;
    logic [2:0] btn;
    logic [2:0] lvl;
    logic [2:0] rise;
    logic [2:0] fall;
  } vec_t;

  vec_t vecs[$];

  gpio_debounce #(
    .WIDTH(3),
    .CNT_W(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .btn_i  (btn),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(input logic r, input logic [2:0] b, input logic [2:0] l,
                                 input logic [2:0] ri, input logic [2:0] fa, input int n);
    vec_t v;
    v.rstN = r; v.btn = b; v.lvl = l; v.rise = ri; v.fall = fa;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  // Inputs are driven while clk is low; one rising edge later outputs are sampled on the falling edge.
  task automatic applyStimulus(input logic r, input logic [2:0] b);
    rstN = r;
    btn  = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [2:0] actual,
                             input logic [2:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s step %0d: got %b, expected %b", name, idx, actual, expected);
    end
  endtask

  initial begin
    int t1, t2;

    // Reset held with all buttons pressed
    addVec(0, 3'b111, 3'b000, 3'b000, 3'b000, 3);
    addVec(1, 3'b000, 3'b000, 3'b000, 3'b000, 2);
    // Clean press on channel 0 captured at step 5, accepted after step 10
    addVec(1, 3'b001, 3'b000, 3'b000, 3'b000, 5);
    addVec(1, 3'b001, 3'b001, 3'b001, 3'b000, 1);
    // Three-cycle glitch on channel 1 must be rejected
    addVec(1, 3'b011, 3'b001, 3'b000, 3'b000, 3);
    addVec(1, 3'b001, 3'b001, 3'b000, 3'b000, 4);
    // Bounce on channel 2: 1,1,1,0 then steady 1
    addVec(1, 3'b101, 3'b001, 3'b000, 3'b000, 3);
    addVec(1, 3'b001, 3'b001, 3'b000, 3'b000, 1);
    addVec(1, 3'b101, 3'b001, 3'b000, 3'b000, 5);
    addVec(1, 3'b101, 3'b101, 3'b100, 3'b000, 1);
    // Bring channel 1 up so all three are high
    addVec(1, 3'b111, 3'b101, 3'b000, 3'b000, 5);
    addVec(1, 3'b111, 3'b111, 3'b010, 3'b000, 1);
    addVec(1, 3'b111, 3'b111, 3'b000, 3'b000, 1);
    // Simultaneous release of all channels
    addVec(1, 3'b000, 3'b111, 3'b000, 3'b000, 5);
    addVec(1, 3'b000, 3'b000, 3'b000, 3'b111, 1);
    addVec(1, 3'b000, 3'b000, 3'b000, 3'b000, 1);
    // Reset mid-count discards progress on channel 0
    addVec(1, 3'b001, 3'b000, 3'b000, 3'b000, 3);
    addVec(0, 3'b001, 3'b000, 3'b000, 3'b000, 1);
    addVec(1, 3'b001, 3'b000, 3'b000, 3'b000, 5);
    addVec(1, 3'b001, 3'b001, 3'b001, 3'b000, 1);

    $display("[TB] running %0d table steps", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].btn);
      checkOutput("level", i, level, vecs[i].lvl);
      checkOutput("rise", i, rise, vecs[i].rise & EdgeMask);
      checkOutput("fall", i, fall, vecs[i].fall & EdgeMask);
    end

    // Staggered presses: channel 1 at step 0, channel 2 at step 2; each accepted on its own count
    t1 = -1;
    t2 = -1;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, (c >= 2) ? 3'b111 : 3'b011);
      if (level[1] && t1 < 0) t1 = c;
      if (level[2] && t2 < 0) t2 = c;
      if (!level[0]) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL hold0 step %0d: got level %b, expected bit0 high", c, level);
      end
    end
    checkOutput("stagger_ch1", 0, 3'(t1), 3'd5);
    checkOutput("stagger_ch2", 0, 3'(t2), 3'd7);
    checkCount++;
    if (t1 < 0 || t2 < 0) begin
      errorCount++;
      $display("[TB] FAIL stagger_timeout: got t1=%0d t2=%0d, expected 5 and 7", t1, t2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
